// File: rtl/sample_src_pkg.sv
// Shared types and constants for the batch sample source.
package sample_src_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int                LFSR_W       = 16;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    // One step of the 16-bit Fibonacci LFSR: taps 0,2,3,5 shift in at the top.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
        return {l[0] ^ l[2] ^ l[3] ^ l[5], l[LFSR_W-1:1]};
    endfunction

endpackage

// File: rtl/sample_batch_source_flex_counter.sv
// Modulo-N counter used as the inter-sample gap timer. Counts 0..rollover_val-1
// while enabled; the rollover flag marks the last enabled cycle of each period.
module flex_counter #(
    parameter int NUM_CNT_BITS = 4
) (
    input  logic                    i_clk,
    input  logic                    i_n_reset,
    input  logic                    i_clear,
    input  logic                    i_count_enable,
    input  logic [NUM_CNT_BITS-1:0] i_rollover_val,
    output logic                    o_rollover_flag
);

    localparam logic [NUM_CNT_BITS-1:0] CNT_ONE = NUM_CNT_BITS'(1);

    logic [NUM_CNT_BITS-1:0] r_count;
    logic                    w_at_terminal;

    assign w_at_terminal   = (r_count == (i_rollover_val - CNT_ONE));
    assign o_rollover_flag = i_count_enable & w_at_terminal;

    // Count register: clear has priority, wraps to zero after the terminal value.
    always_ff @(posedge i_clk or negedge i_n_reset) begin
        if (!i_n_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_count_enable) begin
            r_count <= w_at_terminal ? '0 : (r_count + CNT_ONE);
        end
    end

endmodule

// File: rtl/sample_batch_source.sv
// Batch sample producer: emits BATCH_LEN LFSR samples per start over valid/ready,
// with a one-cycle cnt_up strobe per accepted sample and an optional idle gap.
module sample_batch_source
    import sample_src_pkg::*;
#(
    parameter int                BATCH_LEN = 1000,
    parameter int                CNT_W     = 10,
    parameter int                GAP_W     = 8,
    parameter logic [LFSR_W-1:0] SEED      = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              n_reset,
    input  logic              start,
    input  logic              abort,
    input  logic [GAP_W-1:0]  gap_cycles,
    input  logic              sample_ready,
    output logic              sample_valid,
    output logic [LFSR_W-1:0] sample_data,
    output logic              cnt_up,
    output logic [CNT_W-1:0]  sample_index,
    output logic              busy,
    output logic              batch_done
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(BATCH_LEN - 1);
    localparam logic [CNT_W-1:0] IDX_ONE  = CNT_W'(1);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_valid;
    logic               r_cnt_up;
    logic               r_busy;
    logic               r_done;
    logic [LFSR_W-1:0]  r_lfsr;
    logic [LFSR_W-1:0]  r_data;
    logic [CNT_W-1:0]   r_index;
    logic [GAP_W-1:0]   r_gap;

    logic               w_hs;
    logic               w_start;
    logic               w_last;
    logic               w_gap_entry;
    logic               w_in_gap;
    logic               w_gap_done;
    logic [LFSR_W-1:0]  w_lfsr_adv;

    // r_valid is high exactly while in SEND, so it doubles as the handshake qualifier.
    assign w_hs        = r_valid & sample_ready;
    assign w_start     = (r_state == IDLE) & start & ~abort;
    assign w_last      = (r_index == LAST_IDX);
    assign w_gap_entry = w_hs & ~abort & ~w_last & (r_gap != '0);
    assign w_in_gap    = (r_state == GAP);
    assign w_lfsr_adv  = lfsr_step(r_lfsr);

    flex_counter #(
        .NUM_CNT_BITS (GAP_W)
    ) u_gap_timer (
        .i_clk           (clk),
        .i_n_reset       (n_reset),
        .i_clear         (w_gap_entry),
        .i_count_enable  (w_in_gap),
        .i_rollover_val  (r_gap),
        .o_rollover_flag (w_gap_done)
    );

    // State register.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; abort overrides everything, including start.
    always_comb begin
        w_state_nxt = r_state;
        if (abort) begin
            w_state_nxt = IDLE;
        end else begin
            unique case (r_state)
                IDLE: if (start) w_state_nxt = SEND;
                SEND: begin
                    if (w_hs) begin
                        if (w_last)              w_state_nxt = DONE;
                        else if (r_gap != '0)    w_state_nxt = GAP;
                        else                     w_state_nxt = SEND;
                    end
                end
                GAP:  if (w_gap_done) w_state_nxt = SEND;
                DONE: w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    // Registered control outputs decoded from the upcoming state.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_cnt_up <= 1'b0;
        end else begin
            r_valid  <= (w_state_nxt == SEND);
            r_busy   <= (w_state_nxt != IDLE);
            r_done   <= (w_state_nxt == DONE);
            r_cnt_up <= w_hs & ~abort;
        end
    end

    // Sample index: cleared on start or abort, counts uncancelled handshakes.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_index <= '0;
        end else if (abort || w_start) begin
            r_index <= '0;
        end else if (w_hs) begin
            r_index <= r_index + IDX_ONE;
        end
    end

    // LFSR and sample register: seeded on start, stepped on every handshake.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            r_lfsr <= SEED;
            r_data <= '0;
            r_gap  <= '0;
        end else if (w_start) begin
            r_lfsr <= SEED;
            r_data <= SEED;
            r_gap  <= gap_cycles;
        end else if (w_hs) begin
            r_lfsr <= w_lfsr_adv;
            r_data <= w_lfsr_adv;
        end
    end

    assign sample_valid = r_valid;
    assign sample_data  = r_data;
    assign cnt_up       = r_cnt_up;
    assign sample_index = r_index;
    assign busy         = r_busy;
    assign batch_done   = r_done;

endmodule

// File: tb/tb_sample_batch_source.sv
// Directed bench for sample_batch_source with a cycle-level reference model.
module tb_sample_batch_source;

    localparam int BATCH = 1000;

    logic        clk = 1'b0;
    logic        n_reset;
    logic        start;
    logic        abort;
    logic [7:0]  gap_cycles;
    logic        sample_ready;
    logic        sample_valid;
    logic [15:0] sample_data;
    logic        cnt_up;
    logic [9:0]  sample_index;
    logic        busy;
    logic        batch_done;

    sample_batch_source dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .start        (start),
        .abort        (abort),
        .gap_cycles   (gap_cycles),
        .sample_ready (sample_ready),
        .sample_valid (sample_valid),
        .sample_data  (sample_data),
        .cnt_up       (cnt_up),
        .sample_index (sample_index),
        .busy         (busy),
        .batch_done   (batch_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic [15:0] exp_seq [0:BATCH];

    // reference model state: expected outputs for the current cycle
    bit m_valid, m_cnt_up, m_done, m_busy;
    int m_index, m_wait, m_gap;

    // observation statistics
    int valid_cnt, first_valid, last_valid;
    int cnt_cnt, first_cnt, last_cnt;
    int done_cnt, done_cyc;
    int busy_seen, busy_fall;
    int data_n;
    logic [15:0] first_data, second_data;
    int prev_valid_cyc, gap_min, gap_max;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic clear_stats();
        valid_cnt = 0; first_valid = -1; last_valid = -1;
        cnt_cnt = 0; first_cnt = -1; last_cnt = -1;
        done_cnt = 0; done_cyc = -1;
        busy_seen = 0; busy_fall = -1;
        data_n = 0; first_data = '0; second_data = '0;
        prev_valid_cyc = -1; gap_min = 1000000; gap_max = -1;
    endtask

    task automatic model_reset();
        m_valid = 0; m_cnt_up = 0; m_done = 0; m_busy = 0;
        m_index = 0; m_wait = 0; m_gap = 0;
    endtask

    // Advance the model by one clock using the inputs present at the edge.
    task automatic model_step();
        bit hs;
        bit was_done;
        hs = m_valid && sample_ready;
        if (abort) begin
            model_reset();
        end else begin
            was_done = m_done;
            m_cnt_up = hs;
            m_done   = 0;
            if (hs) begin
                m_index++;
                if (m_index == BATCH) begin
                    m_valid = 0;
                    m_done  = 1;
                end else if (m_gap != 0) begin
                    m_valid = 0;
                    m_wait  = m_gap;
                end
            end else if (m_busy && !m_valid && m_wait > 0) begin
                m_wait--;
                if (m_wait == 0) m_valid = 1;
            end else if (was_done) begin
                m_busy = 0;
            end else if (!m_busy && start) begin
                m_gap   = int'(gap_cycles);
                m_index = 0;
                m_valid = 1;
                m_busy  = 1;
            end
        end
    endtask

    // Model update plus per-cycle comparison, sampled 1 time unit after each event.
    initial begin
        model_reset();
        clear_stats();
        forever begin
            @(posedge clk or negedge n_reset);
            if (!n_reset) begin
                model_reset();
            end else begin
                cyc++;
                model_step();
            end
            #1;
            chk("valid",  {31'd0, sample_valid}, {31'd0, m_valid});
            chk("busy",   {31'd0, busy},         {31'd0, m_busy});
            chk("cnt_up", {31'd0, cnt_up},       {31'd0, m_cnt_up});
            chk("done",   {31'd0, batch_done},   {31'd0, m_done});
            chk("index",  {22'd0, sample_index}, m_index);
            if (m_valid) chk("data", {16'd0, sample_data}, {16'd0, exp_seq[m_index]});
            if (sample_valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
                last_valid = cyc;
                if (data_n == 0) first_data = sample_data;
                else if (data_n == 1) second_data = sample_data;
                data_n++;
                if (prev_valid_cyc >= 0 && (cyc - prev_valid_cyc) > 1) begin
                    if (cyc - prev_valid_cyc - 1 < gap_min) gap_min = cyc - prev_valid_cyc - 1;
                    if (cyc - prev_valid_cyc - 1 > gap_max) gap_max = cyc - prev_valid_cyc - 1;
                end
                prev_valid_cyc = cyc;
            end
            if (cnt_up) begin
                cnt_cnt++;
                if (first_cnt < 0) first_cnt = cyc;
                last_cnt = cyc;
            end
            if (batch_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (busy) busy_seen = 1;
            else if (busy_seen != 0 && busy_fall < 0) busy_fall = cyc;
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < budget);
        chk("idle_timeout", {31'd0, busy}, 32'd0);
    endtask

    task automatic pulse_start(input logic [7:0] gap, output int s0);
        gap_cycles = gap;
        start      = 1'b1;
        s0         = cyc;
        @(negedge clk);
        start      = 1'b0;
    endtask

    initial begin
        int s0;
        int n;
        logic [15:0] x;
        logic [15:0] held;

        n_reset = 1'b0; start = 1'b0; abort = 1'b0; gap_cycles = '0; sample_ready = 1'b0;

        x = 16'hACE1;
        for (int i = 0; i <= BATCH; i++) begin
            exp_seq[i] = x;
            x = {x[0] ^ x[2] ^ x[3] ^ x[5], x[15:1]};
        end
        chk("model_seq0", {16'd0, exp_seq[0]}, 32'h0000ACE1);
        chk("model_seq1", {16'd0, exp_seq[1]}, 32'h00005670);

        // reset state
        repeat (3) @(negedge clk);
        chk("rst_valid", {31'd0, sample_valid}, 32'd0);
        chk("rst_data",  {16'd0, sample_data},  32'd0);
        chk("rst_cnt",   {31'd0, cnt_up},       32'd0);
        chk("rst_index", {22'd0, sample_index}, 32'd0);
        chk("rst_busy",  {31'd0, busy},         32'd0);
        chk("rst_done",  {31'd0, batch_done},   32'd0);
        n_reset = 1'b1;
        repeat (2) @(negedge clk);

        // full batch, no gap, ready always high
        clear_stats();
        sample_ready = 1'b1;
        pulse_start(8'd0, s0);
        wait_idle(1200);
        chk("t1_first_valid", first_valid - s0, 32'd1);
        chk("t1_last_valid",  last_valid - s0,  32'd1000);
        chk("t1_valid_cnt",   valid_cnt,        32'd1000);
        chk("t1_first_cnt",   first_cnt - s0,   32'd2);
        chk("t1_last_cnt",    last_cnt - s0,    32'd1001);
        chk("t1_cnt_cnt",     cnt_cnt,          32'd1000);
        chk("t1_done_cyc",    done_cyc - s0,    32'd1001);
        chk("t1_done_cnt",    done_cnt,         32'd1);
        chk("t1_busy_fall",   busy_fall - s0,   32'd1002);
        chk("t1_index_hold",  {22'd0, sample_index}, 32'd1000);
        chk("t2_first_data",  {16'd0, first_data},   32'h0000ACE1);
        chk("t2_second_data", {16'd0, second_data},  32'h00005670);

        // backpressure on the third sample
        clear_stats();
        pulse_start(8'd0, s0);
        @(negedge clk);
        @(negedge clk);
        sample_ready = 1'b0;
        held = sample_data;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("t3_valid", {31'd0, sample_valid}, 32'd1);
            chk("t3_data",  {16'd0, sample_data},  {16'd0, held});
            chk("t3_cnt",   {31'd0, cnt_up},       32'd0);
            chk("t3_index", {22'd0, sample_index}, 32'd2);
        end
        sample_ready = 1'b1;
        wait_idle(1200);
        chk("t3_cnt_cnt",  cnt_cnt,  32'd1000);
        chk("t3_done_cnt", done_cnt, 32'd1);

        // gap of 3 idle cycles; changing gap_cycles after start must not matter
        clear_stats();
        pulse_start(8'd3, s0);
        gap_cycles = 8'd0;
        wait_idle(4500);
        chk("t4_gap_min",   gap_min,   32'd3);
        chk("t4_gap_max",   gap_max,   32'd3);
        chk("t4_valid_cnt", valid_cnt, 32'd1000);
        chk("t4_cnt_cnt",   cnt_cnt,   32'd1000);
        chk("t4_done_cnt",  done_cnt,  32'd1);

        // abort with a handshake in flight at index 500
        clear_stats();
        pulse_start(8'd0, s0);
        n = 0;
        while (sample_index != 10'd500 && n < 700) begin
            @(negedge clk);
            n++;
        end
        chk("t5_reach_500", {22'd0, sample_index}, 32'd500);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("t5_busy",  {31'd0, busy},         32'd0);
        chk("t5_index", {22'd0, sample_index}, 32'd0);
        chk("t5_valid", {31'd0, sample_valid}, 32'd0);
        chk("t5_cnt",   {31'd0, cnt_up},       32'd0);
        repeat (3) @(negedge clk);
        chk("t5_no_done", done_cnt, 32'd0);
        chk("t5_cnt_cnt", cnt_cnt,  32'd500);

        // restart, then start while busy is ignored
        clear_stats();
        pulse_start(8'd0, s0);
        chk("t5_restart_valid", {31'd0, sample_valid}, 32'd1);
        chk("t5_restart_data",  {16'd0, sample_data},  32'h0000ACE1);
        @(negedge clk);
        gap_cycles = 8'd7;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        gap_cycles = 8'd0;
        repeat (5) @(negedge clk);
        chk("t6_valid", {31'd0, sample_valid}, 32'd1);
        chk("t6_index", {22'd0, sample_index}, 32'd7);
        chk("t6_data",  {16'd0, sample_data},  {16'd0, exp_seq[7]});

        // asynchronous reset mid-batch
        n_reset = 1'b0;
        #1;
        chk("t6_arst_valid", {31'd0, sample_valid}, 32'd0);
        chk("t6_arst_data",  {16'd0, sample_data},  32'd0);
        chk("t6_arst_cnt",   {31'd0, cnt_up},       32'd0);
        chk("t6_arst_index", {22'd0, sample_index}, 32'd0);
        chk("t6_arst_busy",  {31'd0, busy},         32'd0);
        chk("t6_arst_done",  {31'd0, batch_done},   32'd0);
        @(negedge clk);
        n_reset = 1'b1;
        repeat (3) @(negedge clk);
        chk("t6_idle_after", {31'd0, busy}, 32'd0);
        chk("t6_no_done",    done_cnt,      32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
